// File: rtl/key_expansion_seq.sv
// Iterative AES-128 key schedule: one round key per clock, 10 cycles from accepted start to key_valid.
// No backpressure: start is taken in IDLE/DONE and ignored while expansion is in progress.
module key_expansion_seq #(
  parameter int ROUNDS = 10
) (
  input  logic         HCLK,
  input  logic         n_rst,
  input  logic         start,
  input  logic [127:0] keyword,
  output logic         busy,
  output logic         key_valid,
  output logic [127:0] subkey0,
  output logic [127:0] subkey1,
  output logic [127:0] subkey2,
  output logic [127:0] subkey3,
  output logic [127:0] subkey4,
  output logic [127:0] subkey5,
  output logic [127:0] subkey6,
  output logic [127:0] subkey7,
  output logic [127:0] subkey8,
  output logic [127:0] subkey9
);

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t       state, state_nxt;
  logic         load, step, last;
  logic [127:0] work, next_key;
  logic [3:0]   rnd;
  logic [7:0]   rcon;
  logic [127:0] sk [ROUNDS];
  logic [31:0]  w0, w1, w2, w3, rot, t, n0, n1, n2, n3;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  assign w0  = work[127:96];
  assign w1  = work[95:64];
  assign w2  = work[63:32];
  assign w3  = work[31:0];
  assign rot = {w3[23:0], w3[31:24]};
  assign t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
               ^ {rcon, 24'h0};
  assign n0  = w0 ^ t;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (rnd == LAST_RND) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      key_valid <= 1'b0;
      work      <= '0;
      rnd       <= '0;
      rcon      <= '0;
      for (int i = 0; i < ROUNDS; i++) sk[i] <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        work      <= keyword;
        rnd       <= '0;
        rcon      <= 8'h01;
        key_valid <= 1'b0;
        busy      <= 1'b1;
      end else if (step) begin
        work <= next_key;
        rnd  <= rnd + 4'd1;
        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        for (int i = 0; i < ROUNDS; i++) begin
          if (rnd == 4'(i)) sk[i] <= next_key;
        end
        if (last) begin
          busy      <= 1'b0;
          key_valid <= 1'b1;
        end
      end
    end
  end

  assign subkey0 = sk[0];
  assign subkey1 = sk[1];
  assign subkey2 = sk[2];
  assign subkey3 = sk[3];
  assign subkey4 = sk[4];
  assign subkey5 = sk[5];
  assign subkey6 = sk[6];
  assign subkey7 = sk[7];
  assign subkey8 = sk[8];
  assign subkey9 = sk[9];

endmodule

// File: tb/tb_key_expansion_seq.sv
// Scoreboard bench for key_expansion_seq: expected schedules queued at start acceptance,
// monitor compares them when key_valid rises.
module tb_key_expansion_seq;

  // Packed schedules, subkey9 in the top 128 bits, subkey0 in the bottom.
  localparam logic [1279:0] KS_NIST = {
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 128'hac7766f319fadc2128d12941575c006e,
    128'head27321b58dbad2312bf5607f8d292f, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hf2c295f27a96b9435935807a7359f67f, 128'ha0fafe1788542cb123a339392a6c7605
  };
  localparam logic [1279:0] KS_ZERO = {
    128'hb4ef5bcb3e92e21123e951cf6f8f188e, 128'hb1d4d8e28a7db9da1d7bb3de4c664941,
    128'h0ef903333ba9613897060a04511dfa9f, 128'h217517873550620bacaf6b3cc61bf09b,
    128'hec614b851425758c99ff09376ab49ba7, 128'h7f2e2b88f8443e098dda7cbbf34b9290,
    128'hee06da7b876a1581759e42b27e91ee2b, 128'h90973450696ccffaf2f457330b0fac99,
    128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, 128'h62636363626363636263636362636363
  };
  localparam logic [1279:0] KS_FIPS = {
    128'h13111d7fe3944a17f307a78b4d2b30c5, {8{128'h0}}, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe
  };
  localparam logic [127:0] KEY_NIST = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_FIPS = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [9:0]   ALL      = 10'h3ff;
  localparam logic [9:0]   ENDS     = 10'b10_0000_0001;

  typedef struct packed {
    logic [1279:0] sk;
    logic [9:0]    mask;
    logic [31:0]   start_cyc;
  } exp_t;

  logic          tb_HCLK = 1'b0;
  logic          n_rst;
  logic          start;
  logic [127:0]  keyword;
  logic          busy, key_valid;
  logic [127:0]  subkey0, subkey1, subkey2, subkey3, subkey4;
  logic [127:0]  subkey5, subkey6, subkey7, subkey8, subkey9;
  logic [1279:0] sk_all;
  logic [31:0]   cyc = 0;
  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;

  key_expansion_seq #(.ROUNDS(10)) dut (
    .HCLK(tb_HCLK), .n_rst(n_rst), .start(start), .keyword(keyword),
    .busy(busy), .key_valid(key_valid),
    .subkey0(subkey0), .subkey1(subkey1), .subkey2(subkey2), .subkey3(subkey3),
    .subkey4(subkey4), .subkey5(subkey5), .subkey6(subkey6), .subkey7(subkey7),
    .subkey8(subkey8), .subkey9(subkey9)
  );

  assign sk_all = {subkey9, subkey8, subkey7, subkey6, subkey5,
                   subkey4, subkey3, subkey2, subkey1, subkey0};

  always #5 tb_HCLK = ~tb_HCLK;
  always @(posedge tb_HCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Drives one start pulse; the schedule is queued once the edge that takes it has passed.
  task automatic issue(input logic [127:0] k, input logic [1279:0] sk, input logic [9:0] m);
    exp_t e;
    @(negedge tb_HCLK);
    start   = 1'b1;
    keyword = k;
    @(negedge tb_HCLK);
    start   = 1'b0;
    keyword = {$urandom, $urandom, $urandom, $urandom};
    e.sk = sk;
    e.mask = m;
    e.start_cyc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(negedge tb_HCLK);
      #1;
    end
    chk("done_timeout", 128'(exp_q.size()), 128'd0);
    exp_q.delete();
  endtask

  // Monitor: compares the queued schedule, latency and busy width on each key_valid rise.
  always @(negedge tb_HCLK) begin
    exp_t e;
    logic kv_prev = 1'b0;
    logic busy_prev = 1'b0;
    int   busy_run = 0;
    if (busy && !busy_prev) busy_run = 1;
    else if (busy) busy_run++;
    if (key_valid && !kv_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: key_valid rose at cycle %0d with nothing queued", cyc);
      end else begin
        e = exp_q.pop_front();
        for (int i = 0; i < 10; i++) begin
          if (e.mask[i]) chk($sformatf("subkey%0d", i), sk_all[i*128 +: 128], e.sk[i*128 +: 128]);
        end
        chk("latency", 128'(cyc - e.start_cyc), 128'd10);
        chk("busy_cycles", 128'(busy_run), 128'd10);
        chk("busy_at_valid", 128'(busy), 128'd0);
      end
    end
    kv_prev   = key_valid;
    busy_prev = busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst   = 1'b0;
    start   = 1'b0;
    keyword = '0;
    #12;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_key_valid", 128'(key_valid), 128'd0);
    for (int i = 0; i < 10; i++) chk($sformatf("rst_subkey%0d", i), sk_all[i*128 +: 128], 128'd0);
    @(negedge tb_HCLK);
    n_rst = 1'b1;

    // Basic schedules, including back-to-back starts from DONE.
    issue(KEY_FIPS, KS_FIPS, ENDS);
    wait_done();
    repeat (3) @(negedge tb_HCLK);
    issue(KEY_NIST, KS_NIST, ALL);
    wait_done();
    repeat (3) @(negedge tb_HCLK);
    chk("hold_subkey9", subkey9, KS_NIST[9*128 +: 128]);
    chk("hold_key_valid", 128'(key_valid), 128'd1);
    issue(128'h0, KS_ZERO, ALL);
    repeat (3) @(negedge tb_HCLK);
    chk("restart_key_valid", 128'(key_valid), 128'd0);
    chk("restart_busy", 128'(busy), 128'd1);
    wait_done();

    // A start during expansion must be ignored; restarting from DONE then takes the new key.
    issue(KEY_NIST, KS_NIST, ALL);
    repeat (3) @(negedge tb_HCLK);
    start   = 1'b1;
    keyword = KEY_FIPS;
    @(negedge tb_HCLK);
    start   = 1'b0;
    wait_done();
    issue(KEY_FIPS, KS_FIPS, ENDS);
    repeat (4) @(negedge tb_HCLK);
    chk("restart_b_key_valid", 128'(key_valid), 128'd0);
    wait_done();

    // Asynchronous reset mid-expansion clears everything between edges.
    issue(128'h0, KS_ZERO, ALL);
    repeat (4) @(negedge tb_HCLK);
    #2 n_rst = 1'b0;
    #1;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_key_valid", 128'(key_valid), 128'd0);
    for (int i = 0; i < 10; i++) chk($sformatf("abort_subkey%0d", i), sk_all[i*128 +: 128], 128'd0);
    void'(exp_q.pop_back());
    @(negedge tb_HCLK);
    n_rst = 1'b1;
    issue(KEY_NIST, KS_NIST, ALL);
    wait_done();

    repeat (2) @(negedge tb_HCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
